mod_mul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one radix-4 interleaved modular multiplier (enable_p/done_irq_p

---
 rtl/mod_mul_rr_sched.sv | 155 +++++++++++++++
 tb/tb_mod_mul_rr_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_rr_sched.sv
// Round-robin scheduler that shares one modular multiplier among NREQ requesters.
// Grants a requester, captures its operands, screens illegal operands, launches the
// multiplier, waits for completion or timeout and returns the result with the requester id.
module mod_mul_rr_sched #(
  parameter int unsigned NBITS   = 4096,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 2100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*NBITS-1:0]      req_a,
  input  logic [NREQ*NBITS-1:0]      req_b,
  input  logic [NREQ*NBITS-1:0]      req_m,
  output logic [NREQ-1:0]            req_ack,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [NBITS-1:0]           rsp_y,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       mm_enable_p,
  output logic [NBITS-1:0]           mm_a,
  output logic [NBITS-1:0]           mm_b,
  output logic [NBITS-1:0]           mm_m,
  input  logic [NBITS-1:0]           mm_y,
  input  logic                       mm_done_irq_p
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [TW-1:0]      timer_q;
  logic               illegal_q;
  logic               timeout_hit;

  logic [IDW-1:0]     gnt;
  logic               gnt_found;
  int unsigned        scan_idx;
  logic [NBITS-1:0]   sel_a, sel_b, sel_m;
  logic               sel_illegal;

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // Round-robin search: first pending request starting at ptr_q, wrapping at NREQ.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % NREQ;
      if (!gnt_found && req[scan_idx]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(scan_idx);
      end
    end
  end

  // Granted requester's operand slices and the legality screen.
  always_comb begin
    sel_a       = req_a[gnt*NBITS +: NBITS];
    sel_b       = req_b[gnt*NBITS +: NBITS];
    sel_m       = req_m[gnt*NBITS +: NBITS];
    sel_illegal = (sel_m == '0) || (sel_a >= sel_m) || (sel_b >= sel_m);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done wins over timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (gnt_found) state_d = StLaunch;
      StLaunch: state_d = illegal_q ? StResp : StWait;
      StWait:   if (mm_done_irq_p || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    req_ack     = '0;
    mm_enable_p = 1'b0;
    rsp_valid   = (state_q == StResp);
    busy        = (state_q != StIdle);
    if (state_q == StLaunch) begin
      req_ack[rsp_id] = 1'b1;
      mm_enable_p     = ~illegal_q;
    end
  end

  // Operand capture, wait timer, result registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      mm_m      <= '0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            mm_a      <= sel_a;
            mm_b      <= sel_b;
            mm_m      <= sel_m;
            rsp_id    <= gnt;
            illegal_q <= sel_illegal;
          end
        end
        StLaunch: begin
          timer_q <= '0;
          if (illegal_q) begin
            rsp_y   <= '0;
            rsp_err <= 1'b1;
          end
        end
        StWait: begin
          timer_q <= timer_q + TW'(1);
          if (mm_done_irq_p) begin
            rsp_y   <= mm_y;
            rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            rsp_y   <= '0;
            rsp_err <= 1'b1;
          end
        end
        StResp: begin
          // Pointer advances only on the response handshake.
          if (rsp_ready) begin
            ptr_q <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_rr_sched.sv
// Bench for mod_mul_rr_sched with a behavioural multiplier stub of programmable latency.
module tb_mod_mul_rr_sched;

  localparam int NBITS   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*NBITS-1:0] req_a = '0, req_b = '0, req_m = '0;
  logic [NREQ-1:0]       req_ack;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [NBITS-1:0]      rsp_y;
  logic                  rsp_err;
  logic                  busy;
  logic                  mm_enable_p;
  logic [NBITS-1:0]      mm_a, mm_b, mm_m;
  logic [NBITS-1:0]      mm_y;
  logic                  mm_done_irq_p;

  int total = 0;
  int bad   = 0;

  int ja[NREQ], jb[NREQ], jm[NREQ];

  always #5 clk = ~clk;

  mod_mul_rr_sched #(
    .NBITS  (NBITS),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_m        (req_m),
    .req_ack      (req_ack),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_y        (rsp_y),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mm_enable_p  (mm_enable_p),
    .mm_a         (mm_a),
    .mm_b         (mm_b),
    .mm_m         (mm_m),
    .mm_y         (mm_y),
    .mm_done_irq_p(mm_done_irq_p)
  );

  // Multiplier stub: enable restarts it; done pulses mul_lat cycles later unless dead.
  int               mul_lat   = 3;
  bit               stub_dead = 1'b0;
  logic             stub_done = 1'b0;
  logic [NBITS-1:0] stub_y    = '0;
  bit               stub_run  = 1'b0;
  int               stub_cnt  = 0;
  int               sa = 0, sb = 0, sm = 1;
  logic             inj_done  = 1'b0;
  logic [NBITS-1:0] inj_y     = '0;

  assign mm_done_irq_p = stub_done | inj_done;
  assign mm_y          = inj_done ? inj_y : stub_y;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (mm_enable_p) begin
      stub_run <= 1'b1;
      stub_cnt <= mul_lat;
      sa <= int'(mm_a);
      sb <= int'(mm_b);
      sm <= int'(mm_m);
    end else if (stub_run) begin
      if (stub_cnt <= 1) begin
        stub_run <= 1'b0;
        if (!stub_dead) begin
          stub_done <= 1'b1;
          stub_y    <= (sm == 0) ? '0 : NBITS'((sa * sb) % sm);
        end
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  function automatic bit ref_err(input int a, input int b, input int m);
    return (m == 0) || (a >= m) || (b >= m);
  endfunction

  function automatic int ref_y(input int a, input int b, input int m);
    if (ref_err(a, b, m)) return 0;
    return (a * b) % m;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; rsp_ready = 1'b0; inj_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_job(input int i, input int a, input int b, input int m);
    ja[i] = a; jb[i] = b; jm[i] = m;
    req_a[i*NBITS +: NBITS] = NBITS'(a);
    req_b[i*NBITS +: NBITS] = NBITS'(b);
    req_m[i*NBITS +: NBITS] = NBITS'(m);
    req[i] = 1'b1;
  endtask

  // Waits (bounded) for rsp_valid; requesters drop req right after their ack.
  task automatic wait_rsp(input int budget, output bit ok, output int cyc,
                          output logic [NREQ-1:0] acks, output int ens, output int pulses);
    ok = 1'b0; cyc = 0; acks = '0; ens = 0; pulses = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mm_enable_p) ens++;
      if (req_ack != '0) begin
        acks |= req_ack;
        pulses++;
        req &= ~req_ack;
      end
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", req_ack); end
    total++; if (mm_enable_p !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", mm_enable_p); end
    total++;
    if ({mm_a, mm_b, mm_m} !== 24'h0) begin
      bad++; $display("FAIL rst_ops got=%h want=0", {mm_a, mm_b, mm_m});
    end
    total++;
    if ({rsp_y, rsp_id, rsp_err} !== 11'h0) begin
      bad++; $display("FAIL rst_rsp got=%h want=0", {rsp_y, rsp_id, rsp_err});
    end
  endtask

  task automatic test_single();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    do_reset();
    mul_lat = 3;
    set_job(1, 7, 9, 13);
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=none want=rsp_valid"); end
    total++;
    if (acks !== 4'b0010 || pulses != 1) begin
      bad++; $display("FAIL single_ack got=%b/%0d want=0010/1", acks, pulses);
    end
    total++; if (ens != 1) begin bad++; $display("FAIL single_en got=%0d want=1", ens); end
    total++; if (rsp_y !== 8'd11) begin bad++; $display("FAIL single_y got=%0d want=11", rsp_y); end
    total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL single_id got=%0d want=1", rsp_id); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", rsp_err); end
    total++;
    if (cyc != mul_lat + 3) begin
      bad++; $display("FAIL single_lat got=%0d want=%0d", cyc, mul_lat + 3);
    end
    consume();
  endtask

  task automatic test_rr_order();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    int exp_ord[6];
    exp_ord = '{0, 2, 3, 0, 1, 2};
    do_reset();
    mul_lat = 2;
    set_job(0, 3, 5, 11);
    set_job(2, 6, 6, 7);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        for (int i = 0; i < NREQ; i++) set_job(i, i + 2, i + 3, 29 - i);
      end
      wait_rsp(100, ok, cyc, acks, ens, pulses);
      total++;
      if (!ok || rsp_id !== 2'(exp_ord[k])) begin
        bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, rsp_id, exp_ord[k]);
      end
      total++;
      if (rsp_y !== NBITS'(ref_y(ja[exp_ord[k]], jb[exp_ord[k]], jm[exp_ord[k]]))) begin
        bad++; $display("FAIL rr_y[%0d] got=%0d", k, rsp_y);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    int ms[2];
    int as[2];
    ms = '{13, 0};
    as = '{13, 5};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_job(3, as[k], 2, ms[k]);
      wait_rsp(100, ok, cyc, acks, ens, pulses);
      total++;
      if (!ok || cyc != 2) begin bad++; $display("FAIL ill_lat[%0d] got=%0d want=2", k, cyc); end
      total++; if (acks !== 4'b1000) begin bad++; $display("FAIL ill_ack got=%b want=1000", acks); end
      total++; if (ens != 0) begin bad++; $display("FAIL ill_en got=%0d want=0", ens); end
      total++;
      if (rsp_err !== 1'b1 || rsp_y !== 8'd0) begin
        bad++; $display("FAIL ill_rsp got=err%b y%0d want=err1 y0", rsp_err, rsp_y);
      end
      consume();
    end
  endtask

  task automatic test_timeout();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    do_reset();
    stub_dead = 1'b1;
    set_job(2, 4, 5, 9);
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    total++;
    if (!ok || cyc != TIMEOUT + 2) begin
      bad++; $display("FAIL to_lat got=%0d want=%0d", cyc, TIMEOUT + 2);
    end
    total++; if (ens != 1) begin bad++; $display("FAIL to_en got=%0d want=1", ens); end
    total++;
    if (rsp_err !== 1'b1 || rsp_y !== 8'd0) begin
      bad++; $display("FAIL to_rsp got=err%b y%0d want=err1 y0", rsp_err, rsp_y);
    end
    // A late done pulse during RESP must not alter the response.
    inj_y = 8'h5a; inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    total++;
    if (!rsp_valid || rsp_err !== 1'b1 || rsp_y !== 8'd0) begin
      bad++; $display("FAIL to_late got=v%b err%b y%0d want=v1 err1 y0", rsp_valid, rsp_err, rsp_y);
    end
    consume();
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL to_idle_done got=busy%b v%b want=0 0", busy, rsp_valid);
    end
    stub_dead = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    int y0;
    do_reset();
    mul_lat = 4;
    set_job(0, 10, 11, 17);
    y0 = ref_y(10, 11, 17);
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    set_job(0, 4, 5, 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (!rsp_valid || rsp_id !== 2'd0 || rsp_y !== NBITS'(y0) || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=v%b id%0d y%0d e%b want=v1 id0 y%0d e0",
                 k, rsp_valid, rsp_id, rsp_y, rsp_err, y0);
      end
      total++;
      if (req_ack !== 4'b0 || busy !== 1'b1 || mm_a !== 8'd10) begin
        bad++; $display("FAIL bp_stall[%0d] got=ack%b busy%b a%0d", k, req_ack, busy, mm_a);
      end
    end
    consume();
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    total++;
    if (!ok || rsp_y !== NBITS'(ref_y(4, 5, 7)) || acks !== 4'b0001) begin
      bad++; $display("FAIL bp_next got=y%0d ack%b want=y%0d ack0001", rsp_y, acks, ref_y(4, 5, 7));
    end
    consume();
  endtask

  task automatic test_rst_mid();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    do_reset();
    mul_lat = 2;
    set_job(2, 5, 6, 11);
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    consume();
    mul_lat = 7;
    set_job(2, 5, 7, 11);
    repeat (3) begin
      @(negedge clk);
      req &= ~req_ack;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ack, rsp_valid, busy, mm_enable_p} !== 7'b0) begin
      bad++; $display("FAIL rstmid_ctl got=%b want=0", {req_ack, rsp_valid, busy, mm_enable_p});
    end
    total++;
    if ({mm_a, mm_b, mm_m, rsp_y, rsp_id, rsp_err} !== 35'h0) begin
      bad++; $display("FAIL rstmid_data got=%h want=0", {mm_a, mm_b, mm_m, rsp_y, rsp_id, rsp_err});
    end
    rst = 1'b0;
    mul_lat = 3;
    set_job(1, 3, 4, 13);
    set_job(3, 2, 9, 13);
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    total++;
    if (!ok || rsp_id !== 2'd1 || rsp_y !== 8'd12 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_job got=id%0d y%0d e%b want=id1 y12 e0", rsp_id, rsp_y, rsp_err);
    end
    consume();
    wait_rsp(100, ok, cyc, acks, ens, pulses);
    total++;
    if (!ok || rsp_id !== 2'd3 || rsp_y !== NBITS'(ref_y(2, 9, 13))) begin
      bad++; $display("FAIL rstmid_job2 got=id%0d y%0d want=id3 y%0d", rsp_id, rsp_y, ref_y(2, 9, 13));
    end
    consume();
  endtask

  task automatic test_random();
    bit ok; int cyc, ens, pulses; logic [NREQ-1:0] acks;
    logic [NREQ-1:0] pend;
    int mptr, e, a, b, m;
    do_reset();
    mptr = 0;
    for (int it = 0; it < 12; it++) begin
      pend = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255); m = $urandom_range(0, 255);
          end else begin
            m = $urandom_range(1, 255); a = $urandom % m; b = $urandom % m;
          end
          set_job(i, a, b, m);
        end
      end
      mul_lat = $urandom_range(1, 7);
      while (pend != '0) begin
        e = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (e < 0 && pend[(mptr + k) % NREQ]) e = (mptr + k) % NREQ;
        end
        wait_rsp(100, ok, cyc, acks, ens, pulses);
        total++;
        if (!ok || rsp_id !== 2'(e)) begin
          bad++; $display("FAIL rnd_id[%0d] got=%0d want=%0d", it, rsp_id, e);
        end
        total++;
        if (rsp_y !== NBITS'(ref_y(ja[e], jb[e], jm[e])) || rsp_err !== ref_err(ja[e], jb[e], jm[e])) begin
          bad++;
          $display("FAIL rnd_rsp[%0d] got=y%0d e%b want=y%0d e%b", it, rsp_y, rsp_err,
                   ref_y(ja[e], jb[e], jm[e]), ref_err(ja[e], jb[e], jm[e]));
        end
        pend[e] = 1'b0;
        mptr = (e + 1) % NREQ;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        consume();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
